// File: rtl/lab4_3_enable_window_seq_pkg.sv
// Shared state encoding for the enable-window sequencer.
package lab4_3_enable_window_seq_pkg;

  localparam logic [1:0] ENC_IDLE   = 2'd0;
  localparam logic [1:0] ENC_DELAY  = 2'd1;
  localparam logic [1:0] ENC_ACTIVE = 2'd2;
  localparam logic [1:0] ENC_DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = ENC_IDLE,
    ST_DELAY  = ENC_DELAY,
    ST_ACTIVE = ENC_ACTIVE,
    ST_DONE   = ENC_DONE
  } state_e;

endpackage

// File: rtl/lab4_3_enable_window_seq_if.sv
// Request/window bundle between the sequencer and its controller.
interface lab4_3_enable_window_seq_if #(
  parameter int DLY_W = 4,
  parameter int WIN_W = 4
);

  logic             start;
  logic             abort;
  logic [DLY_W-1:0] delay_len;
  logic [WIN_W-1:0] win_len;
  logic             din;
  logic             a;
  logic             enable;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, delay_len, win_len, din,
    input  a, enable, busy, done
  );

  modport slave (
    input  start, abort, delay_len, win_len, din,
    output a, enable, busy, done
  );

endinterface

// File: rtl/lab4_3_down_counter.sv
// Loadable down counter with a zero flag; load has priority over decrement.
module lab4_3_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count selection
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/lab4_3_enable_window_seq.sv
// Start-triggered enable window with programmable delay and length, plus a
// one-cycle registered copy of din; all outputs come straight from flops.
module lab4_3_enable_window_seq
  import lab4_3_enable_window_seq_pkg::*;
#(
  parameter int DLY_W = 4,
  parameter int WIN_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  lab4_3_enable_window_seq_if.slave  bus
);

  state_e state_q, state_d;
  logic   a_q, enable_q, enable_d, busy_q, busy_d, done_q, done_d;
  logic   win_nz_q, win_nz_d;
  logic   dly_load_s, dly_dec_s, dly_zero_s;
  logic   win_load_s, win_dec_s, win_zero_s;

  // Counters hold length-1 so the zero flag marks the final cycle of a phase.
  lab4_3_down_counter #(.W(DLY_W)) u_dly_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (dly_load_s),
    .load_val_i (bus.delay_len - {{(DLY_W-1){1'b0}}, 1'b1}),
    .dec_i      (dly_dec_s),
    .zero_o     (dly_zero_s)
  );

  lab4_3_down_counter #(.W(WIN_W)) u_win_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (win_load_s),
    .load_val_i (bus.win_len - {{(WIN_W-1){1'b0}}, 1'b1}),
    .dec_i      (win_dec_s),
    .zero_o     (win_zero_s)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    enable_d   = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    win_nz_d   = win_nz_q;
    dly_load_s = 1'b0;
    dly_dec_s  = 1'b0;
    win_load_s = 1'b0;
    win_dec_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          dly_load_s = 1'b1;
          win_load_s = 1'b1;
          win_nz_d   = (bus.win_len != {WIN_W{1'b0}});
          if (bus.delay_len != {DLY_W{1'b0}}) begin
            state_d = ST_DELAY;
          end else if (bus.win_len != {WIN_W{1'b0}}) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          busy_d = 1'b1;
          if (dly_zero_s) begin
            state_d = win_nz_q ? ST_ACTIVE : ST_DONE;
          end else begin
            dly_dec_s = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          busy_d   = 1'b1;
          enable_d = 1'b1;
          if (win_zero_s) begin
            state_d = ST_DONE;
          end else begin
            win_dec_s = 1'b1;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      win_nz_q <= 1'b0;
      a_q      <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_nz_q <= win_nz_d;
      a_q      <= bus.din;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.a      = a_q;
  assign bus.enable = enable_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_lab4_3_enable_window_seq.sv
// Directed bench for the enable-window sequencer with a downstream y = enable ? a : 0 gate.
module tb_lab4_3_enable_window_seq;

  logic clk;
  logic rst_n;
  logic y;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   a_err    = 0;
  int   inv_err  = 0;

  logic [31:0] ev, bv, dv, yv, av;
  logic        e0, b0, d0, y0, a0;

  lab4_3_enable_window_seq_if #(.DLY_W(4), .WIN_W(4)) bus ();

  lab4_3_enable_window_seq #(.DLY_W(4), .WIN_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign y = bus.enable ? bus.a : 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(output logic en, output logic bs, output logic dn,
                      output logic yy, output logic aa);
    logic din_at;
    @(posedge clk);
    din_at = bus.din;
    #1;
    if (rst_n) begin
      if (bus.a !== din_at) a_err++;
      if ((bus.enable && !bus.busy) || (bus.done && bus.busy)) inv_err++;
    end
    en = bus.enable;
    bs = bus.busy;
    dn = bus.done;
    yy = y;
    aa = bus.a;
    bus.din = ~bus.din;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(e0, b0, d0, y0, a0);
  endtask

  // Bit k-1 of each vector is the output seen after edge N+k (N = accepting edge).
  task automatic run(input logic [3:0] d, input logic [3:0] w,
                     input logic [3:0] alt_d, input logic [3:0] alt_w,
                     input int n, input int abort_k, input logic [31:0] smask,
                     output logic [31:0] o_ev, output logic [31:0] o_bv,
                     output logic [31:0] o_dv, output logic [31:0] o_yv,
                     output logic [31:0] o_av);
    logic e, b, dn, yy, aa;
    bus.delay_len = d;
    bus.win_len   = w;
    bus.start     = 1'b1;
    bus.abort     = 1'b0;
    tick(e, b, dn, yy, aa);
    bus.delay_len = alt_d;
    bus.win_len   = alt_w;
    o_ev = 32'd0; o_bv = 32'd0; o_dv = 32'd0; o_yv = 32'd0; o_av = 32'd0;
    for (int k = 1; k <= n; k++) begin
      bus.start = smask[k];
      bus.abort = (k == abort_k);
      tick(e, b, dn, yy, aa);
      o_ev[k-1] = e;
      o_bv[k-1] = b;
      o_dv[k-1] = dn;
      o_yv[k-1] = yy;
      o_av[k-1] = aa;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.delay_len = 4'd0;
    bus.win_len   = 4'd0;
    bus.din       = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_outputs", {28'd0, bus.a, bus.enable, bus.busy, bus.done}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // delay 3, window 2; inputs changed after accept must not matter
    run(4'd3, 4'd2, 4'd7, 4'd9, 8, 0, 32'd0, ev, bv, dv, yv, av);
    check_eq("t2_enable", ev, 32'h18);
    check_eq("t2_busy",   bv, 32'h1F);
    check_eq("t2_done",   dv, 32'h20);
    check_eq("t2_y_gate", yv, av & 32'h18);
    idle(2);

    run(4'd0, 4'd1, 4'd0, 4'd1, 4, 0, 32'd0, ev, bv, dv, yv, av);
    check_eq("t3_d0w1_enable", ev, 32'h1);
    check_eq("t3_d0w1_busy",   bv, 32'h1);
    check_eq("t3_d0w1_done",   dv, 32'h2);
    idle(2);

    run(4'd0, 4'd0, 4'd0, 4'd0, 4, 0, 32'd0, ev, bv, dv, yv, av);
    check_eq("t3_d0w0_enable", ev, 32'h0);
    check_eq("t3_d0w0_busy",   bv, 32'h0);
    check_eq("t3_d0w0_done",   dv, 32'h1);
    idle(2);

    // abort sampled at the edge closing the second enable-high cycle
    run(4'd1, 4'd5, 4'd1, 4'd5, 10, 4, 32'd0, ev, bv, dv, yv, av);
    check_eq("t4_abort_enable", ev, 32'h6);
    check_eq("t4_abort_busy",   bv, 32'h7);
    check_eq("t4_abort_done",   dv, 32'h0);
    idle(2);

    bus.delay_len = 4'd1;
    bus.win_len   = 4'd1;
    bus.start     = 1'b1;
    bus.abort     = 1'b1;
    tick(e0, b0, d0, y0, a0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bv = 32'd0;
    for (int i = 0; i < 4; i++) begin
      tick(e0, b0, d0, y0, a0);
      bv[i] = b0 | e0 | d0;
    end
    check_eq("t4_start_abort_idle", bv, 32'h0);
    idle(1);

    // start during DELAY (edge N+1) and DONE (edge N+5) ignored
    run(4'd2, 4'd2, 4'd2, 4'd2, 12, 0, 32'h0000_0022, ev, bv, dv, yv, av);
    check_eq("t5_ignored_enable", ev, 32'h00C);
    check_eq("t5_ignored_busy",   bv, 32'h00F);
    check_eq("t5_ignored_done",   dv, 32'h010);
    idle(2);

    // start in the first IDLE cycle after DONE (edge N+6) accepted
    run(4'd2, 4'd2, 4'd2, 4'd2, 12, 0, 32'h0000_0040, ev, bv, dv, yv, av);
    check_eq("t5_restart_enable", ev, 32'h30C);
    check_eq("t5_restart_busy",   bv, 32'h3CF);
    check_eq("t5_restart_done",   dv, 32'h410);
    idle(2);

    run(4'd15, 4'd15, 4'd15, 4'd15, 32, 0, 32'd0, ev, bv, dv, yv, av);
    check_eq("t6_full_enable", ev, 32'h3FFF_8000);
    check_eq("t6_full_busy",   bv, 32'h3FFF_FFFF);
    check_eq("t6_full_done",   dv, 32'h4000_0000);
    idle(2);

    // asynchronous reset while enable is high
    bus.delay_len = 4'd0;
    bus.win_len   = 4'd5;
    bus.start     = 1'b1;
    tick(e0, b0, d0, y0, a0);
    bus.start = 1'b0;
    bus.din   = 1'b1;
    tick(e0, b0, d0, y0, a0);
    check_eq("t1_pre_enable", {30'd0, e0, a0}, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t1_async_rst", {28'd0, bus.a, bus.enable, bus.busy, bus.done}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    bv = 32'd0;
    for (int i = 0; i < 3; i++) begin
      tick(e0, b0, d0, y0, a0);
      bv[i] = b0 | e0 | d0;
    end
    check_eq("t1_idle_after_rel", bv, 32'h0);

    check_eq("a_tracks_din", a_err, 32'd0);
    check_eq("invariants",   inv_err, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
